// File: rtl/button_cmd_arbiter.sv
// button_cmd_arbiter
//   Front-panel button controller. Each raw button input is synchronised,
//   debounced and turned into a single press event; pending events are
//   round-robin arbitrated onto one valid/ready command port.
//
// Optional feature: define BTN_AUTOREPEAT_EN to re-issue events while a
// button is held (first after REPEAT_DELAY cycles, then every
// REPEAT_PERIOD cycles). Without it, each debounced press gives one event.
//
// Ports
//   clk          in   rising-edge system clock
//   reset        in   asynchronous reset, active low
//   btn_raw      in   [NUM_BTN] raw button levels, 1 = pressed
//   btn_level    out  [NUM_BTN] debounced button levels
//   cmd_valid    out  command available on cmd_id
//   cmd_ready    in   consumer accepts when cmd_valid & cmd_ready
//   cmd_id       out  [$clog2(NUM_BTN)] index of the commanding button
//   evt_dropped  out  1-cycle pulse: a press merged into a pending event
module button_cmd_arbiter #(
  parameter int NUM_BTN         = 4,
  parameter int DB_W            = 20,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         btn_raw,
  output logic [NUM_BTN-1:0]         btn_level,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [$clog2(NUM_BTN)-1:0] cmd_id,
  output logic                       evt_dropped
);

  localparam int ID_W = $clog2(NUM_BTN);

  if (NUM_BTN < 2 || NUM_BTN > 16) begin : g_bad_num_btn
    $error("NUM_BTN must be in 2..16");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES >= (64'd1 << DB_W)) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 2 and fit in DB_W bits");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_repeat
    $error("REPEAT_PERIOD must be >= 1 and <= REPEAT_DELAY");
  end

  logic [NUM_BTN-1:0] sync_p0, sync_p1;
  logic [DB_W-1:0]    db_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] level_d;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] press, rep, set_evt, clr_evt;
  logic [ID_W-1:0]    rr, win_idx;
  logic               win_found, load;

  // Stage p0/p1: two-flop synchroniser, then per-bit debounce on sync_p1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      btn_level <= '0;
      level_d   <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      level_d <= btn_level;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync_p1[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_level[i] <= ~btn_level[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Release edges are deliberately ignored: only 0->1 makes an event
  assign press = btn_level & ~level_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  logic [HOLD_W-1:0] hold_cnt [NUM_BTN];

  // hold_cnt is 0 on the cycle the press is detected, so reaching
  // REPEAT_DELAY marks the first repeat; reloading to DELAY-PERIOD+1
  // makes every later repeat exactly REPEAT_PERIOD cycles apart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BTN; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!btn_level[i])
          hold_cnt[i] <= '0;
        else if (hold_cnt[i] == HOLD_W'(REPEAT_DELAY))
          hold_cnt[i] <= HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
        else
          hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
      end
    end
  end

  // Gated by the live level so a release landing on a repeat slot is silent
  always_comb begin
    rep = '0;
    for (int i = 0; i < NUM_BTN; i++)
      rep[i] = btn_level[i] && (hold_cnt[i] == HOLD_W'(REPEAT_DELAY));
  end
`else
  assign rep = '0;
`endif

  assign set_evt = press | rep;

  // Round-robin search starting just above the last winner, with wrap
  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      j = int'(rr) + k;
      if (j >= NUM_BTN) j = j - NUM_BTN;
      if (!win_found && pending[ID_W'(j)]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(j);
      end
    end
  end

  assign load    = ~cmd_valid | cmd_ready;
  assign clr_evt = (load && win_found) ? (NUM_BTN'(1) << win_idx) : '0;

  // Stage p2: pending set, output register and drop flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending     <= '0;
      rr          <= '0;
      cmd_valid   <= 1'b0;
      cmd_id      <= '0;
      evt_dropped <= 1'b0;
    end else begin
      // A new event on a bit being granted this cycle survives (set wins)
      pending     <= (pending & ~clr_evt) | set_evt;
      evt_dropped <= |(set_evt & pending & ~clr_evt);
      if (load) begin
        cmd_valid <= win_found;
        if (win_found) begin
          cmd_id <= win_idx;
          rr     <= win_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_cmd_arbiter.sv
module tb_button_cmd_arbiter;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int RD = 40;
  localparam int RP = 10;
  localparam int HD = D + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic         cmd_valid;
  logic         cmd_ready = 1'b0;
  logic [1:0]   cmd_id;
  logic         evt_dropped;

  button_cmd_arbiter #(
    .NUM_BTN(N), .DB_W(8), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .evt_dropped(evt_dropped)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model. A level flips once the last D synchronised samples
  // (raw samples 2..D+1 edges old) all disagree with it; a rise queues an
  // event for the next edge; grants go to the first pending index after
  // the previous grant.
  bit [N-1:0] m_hist [HD];
  bit [N-1:0] m_lvl, m_rise, m_pend;
  bit         m_valid, m_drop;
  int         m_id, m_last, m_edge;
  int         m_pedge [N];

  always begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      foreach (m_hist[a]) m_hist[a] = '0;
      m_lvl = '0; m_rise = '0; m_pend = '0;
      m_valid = 1'b0; m_drop = 1'b0;
      m_id = 0; m_last = 0; m_edge = 0;
      foreach (m_pedge[b]) m_pedge[b] = -1;
    end else begin
      bit [N-1:0] lvl_n, set, clr;
      bit opp;
      int w;
      m_edge++;
      for (int a = HD - 1; a > 0; a--) m_hist[a] = m_hist[a-1];
      m_hist[0] = btn_raw;
      lvl_n = m_lvl;
      for (int b = 0; b < N; b++) begin
        opp = 1'b1;
        for (int a = 2; a < HD; a++) if (m_hist[a][b] == m_lvl[b]) opp = 1'b0;
        if (opp) lvl_n[b] = ~m_lvl[b];
      end
      set = m_rise;
`ifdef BTN_AUTOREPEAT_EN
      for (int b = 0; b < N; b++) begin
        if (m_rise[b]) m_pedge[b] = m_edge;
        else if (!m_lvl[b]) m_pedge[b] = -1;
        else if (m_pedge[b] >= 0 && m_edge - m_pedge[b] >= RD &&
                 (m_edge - m_pedge[b] - RD) % RP == 0) set[b] = 1'b1;
      end
`endif
      clr = '0;
      if (!m_valid || cmd_ready) begin
        m_valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
          w = (m_last + k) % N;
          if (!m_valid && m_pend[w]) begin
            m_valid = 1'b1; m_id = w; clr[w] = 1'b1;
          end
        end
        if (m_valid) m_last = m_id;
      end
      m_drop = |(set & m_pend & ~clr);
      m_pend = (m_pend & ~clr) | set;
      m_rise = lvl_n & ~m_lvl;
      m_lvl  = lvl_n;
    end
  end

  // Per-cycle compare plus trace of accepted commands
  int edge_no = 0;
  int acc_q[$];
  int acc_e[$];
  int n_drop, n_vcyc, first_valid, first_lvl, watch;

  always begin
    bit acc_now;
    int acc_id;
    @(posedge clk);
    acc_now = cmd_valid && cmd_ready;
    acc_id  = int'(cmd_id);
    edge_no++;
    #1;
    chk("btn_level", int'(btn_level), int'(m_lvl));
    chk("cmd_valid", int'(cmd_valid), int'(m_valid));
    if (m_valid) chk("cmd_id", int'(cmd_id), m_id);
    chk("evt_dropped", int'(evt_dropped), int'(m_drop));
    if (acc_now) begin acc_q.push_back(acc_id); acc_e.push_back(edge_no); end
    if (cmd_valid) begin
      n_vcyc++;
      if (first_valid < 0) first_valid = edge_no;
    end
    if (btn_level[watch] && first_lvl < 0) first_lvl = edge_no;
    if (evt_dropped) n_drop++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark(input int bit_i);
    acc_q.delete(); acc_e.delete();
    n_drop = 0; n_vcyc = 0; first_valid = -1; first_lvl = -1; watch = bit_i;
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  int e0;
  int exp_ids_c[3] = '{0, 1, 3};
  int rep_off[5] = '{0, 40, 50, 60, 70};

  initial begin
    mark(0);
    tick(3);
    chk("reset cmd_valid", int'(cmd_valid), 0);
    chk("reset cmd_id", int'(cmd_id), 0);
    chk("reset btn_level", int'(btn_level), 0);
    chk("reset evt_dropped", int'(evt_dropped), 0);
    reset = 1'b1;
    tick(3);

    // Clean press on bit 2
    mark(2);
    cmd_ready = 1'b1;
    btn_raw[2] = 1'b1;
    e0 = edge_no + 1;
    tick(20);
    chk("clean level latency", first_lvl - e0, 9);
    chk("clean valid latency", first_valid - e0, 11);
    chk("clean valid cycles", n_vcyc, 1);
    chk("clean cmd count", acc_q.size(), 1);
    chk("clean cmd id", qget(acc_q, 0), 2);
    btn_raw[2] = 1'b0;
    tick(20);

    // Bounce on bit 1: 3-cycle pulses, then a steady high
    mark(1);
    for (int t = 0; t < 10; t++) begin
      btn_raw[1] = ~btn_raw[1];
      tick(3);
    end
    btn_raw[1] = 1'b1;
    e0 = edge_no + 1;
    tick(20);
    chk("bounce level latency", first_lvl - e0, 9);
    chk("bounce cmd count", acc_q.size(), 1);
    chk("bounce cmd id", qget(acc_q, 0), 1);
    btn_raw[1] = 1'b0;
    tick(15);

    // Single press on bit 3 leaves the rr pointer at 3
    mark(3);
    btn_raw[3] = 1'b1;
    tick(14);
    btn_raw[3] = 1'b0;
    tick(15);
    chk("rr setup cmd id", qget(acc_q, 0), 3);

    // Backpressure and round robin over bits 0,1,3
    mark(0);
    cmd_ready = 1'b0;
    btn_raw = 4'b1011;
    tick(20);
    chk("stall valid", int'(cmd_valid), 1);
    chk("stall id", int'(cmd_id), 0);
    cmd_ready = 1'b1;
    tick(6);
    btn_raw = '0;
    tick(15);
    chk("rr cmd count", acc_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("rr order", qget(acc_q, i), exp_ids_c[i]);
    chk("rr back-to-back 1", qget(acc_e, 1) - qget(acc_e, 0), 1);
    chk("rr back-to-back 2", qget(acc_e, 2) - qget(acc_e, 1), 1);

    // Coalesce: three presses of bit 0 while stalled
    mark(0);
    cmd_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      btn_raw[0] = 1'b1;
      tick(14);
      btn_raw[0] = 1'b0;
      tick(14);
    end
    chk("coalesce drops", n_drop, 1);
    chk("coalesce held id", int'(cmd_id), 0);
    cmd_ready = 1'b1;
    tick(6);
    chk("coalesce cmd count", acc_q.size(), 2);
    chk("coalesce id 0", qget(acc_q, 0), 0);
    chk("coalesce id 1", qget(acc_q, 1), 0);

    // Asynchronous reset during a stall, button kept held
    mark(2);
    cmd_ready = 1'b0;
    btn_raw[2] = 1'b1;
    tick(15);
    chk("pre-reset valid", int'(cmd_valid), 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async reset cmd_valid", int'(cmd_valid), 0);
    chk("async reset btn_level", int'(btn_level), 0);
    chk("async reset evt_dropped", int'(evt_dropped), 0);
    tick(3);
    reset = 1'b1;
    mark(2);
    cmd_ready = 1'b1;
    tick(20);
    chk("post-reset cmd count", acc_q.size(), 1);
    chk("post-reset cmd id", qget(acc_q, 0), 2);
    btn_raw[2] = 1'b0;
    tick(15);

    // Long hold on bit 3
    mark(3);
    btn_raw[3] = 1'b1;
    tick(80);
    btn_raw[3] = 1'b0;
    tick(50);
`ifdef BTN_AUTOREPEAT_EN
    chk("hold cmd count", acc_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("hold cmd id", qget(acc_q, i), 3);
      chk("hold repeat offset", qget(acc_e, i) - qget(acc_e, 0), rep_off[i]);
    end
`else
    chk("hold cmd count", acc_q.size(), 1);
    chk("hold cmd id", qget(acc_q, 0), 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
